// File: rtl/regfile_engine.sv
// Signed register file that runs one multi-cycle op at a time (read, write, read-then-write,
// add, sub, shift) with start/busy/done handshaking and programmable phase latencies.
module regfile_engine #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_LAT   = 2,
  parameter int ALU_LAT  = 16,
  parameter int WB_LAT   = 2,
  parameter int SATURATE = 0,
  parameter int ZERO_R0  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [ADDR_W-1:0]        ra,
  input  logic [ADDR_W-1:0]        rb,
  input  logic [ADDR_W-1:0]        w,
  input  logic signed [DATA_W-1:0] wd,
  output logic signed [DATA_W-1:0] rda,
  output logic signed [DATA_W-1:0] rdb,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RD, ALU, WB} state_t;
  localparam logic [2:0] OP_WRITE = 3'd0, OP_READ2 = 3'd2, OP_R1W = 3'd3, OP_R2W = 3'd4,
                         OP_ADD = 3'd5, OP_SUB = 3'd6;

  state_t                   state;
  logic [15:0]              cnt;
  logic [2:0]               op_q;
  logic [ADDR_W-1:0]        ra_q, rb_q, w_q;
  logic signed [DATA_W-1:0] wd_q, res_q;
  logic                     ovf_q;
  logic signed [DATA_W-1:0] regs [NREGS];

  logic signed [DATA_W-1:0] rd_a, rd_b, alu_res, sum_res;
  logic [DATA_W:0]          sum_ext;
  logic                     sum_ovf, wr_ok, reads_b, is_arith;

  // Out-of-range and (optionally) r0 read as zero; the same rule gates writes.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (int'(ra_q) < NREGS && !(ZERO_R0 != 0 && ra_q == '0)) rd_a = regs[ra_q];
    if (int'(rb_q) < NREGS && !(ZERO_R0 != 0 && rb_q == '0)) rd_b = regs[rb_q];
    wr_ok    = int'(w_q) < NREGS && !(ZERO_R0 != 0 && w_q == '0);
    reads_b  = (op_q == OP_READ2) || (op_q == OP_R2W) || (op_q == OP_ADD) || (op_q == OP_SUB);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  end

  // ALU works on the operands captured in rda/rdb at the end of the read phase.
  always_comb begin
    if (op_q == OP_SUB) sum_ext = {rda[DATA_W-1], rda} - {rdb[DATA_W-1], rdb};
    else                sum_ext = {rda[DATA_W-1], rda} + {rdb[DATA_W-1], rdb};
    sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    sum_res = sum_ext[DATA_W-1:0];
    if (SATURATE != 0 && sum_ovf)
      sum_res = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    if (is_arith)               alu_res = sum_res;
    else if (wd_q[DATA_W-1])    alu_res = rda >>> wd_q[SH_W-1:0];
    else                        alu_res = rda << wd_q[SH_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      w_q   <= '0;
      wd_q  <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      rda   <= '0;
      rdb   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            w_q  <= w;
            wd_q <= wd;
            busy <= 1'b1;
            if (op == OP_WRITE) begin
              state <= WB;
              cnt   <= 16'(WB_LAT - 1);
            end else begin
              state <= RD;
              cnt   <= 16'(RD_LAT - 1);
            end
          end
        end
        RD: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            rda <= rd_a;
            if (reads_b) rdb <= rd_b;
            if (op_q >= OP_ADD) begin
              state <= ALU;
              cnt   <= 16'(ALU_LAT - 1);
            end else if (op_q == OP_R1W || op_q == OP_R2W) begin
              state <= WB;
              cnt   <= 16'(WB_LAT - 1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              ovf   <= 1'b0;
            end
          end
        end
        ALU: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            res_q <= alu_res;
            ovf_q <= is_arith && sum_ovf;
            state <= WB;
            cnt   <= 16'(WB_LAT - 1);
          end
        end
        WB: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            if (op_q >= OP_ADD) begin
              if (wr_ok) regs[w_q] <= res_q;
              rda <= res_q;
              ovf <= ovf_q;
            end else begin
              if (wr_ok) regs[w_q] <= wd_q;
              if (op_q == OP_WRITE) rda <= wd_q;
              ovf <= 1'b0;
            end
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_engine.sv
// Directed bench for regfile_engine: default instance u0 plus a saturating, zero-r0,
// 20-register instance u1, both driven by the same stimulus.
module tb_regfile_engine;
  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] op;
  logic [4:0] ra, rb, w;
  logic signed [15:0] wd;
  logic signed [15:0] rda0, rdb0, rda1, rdb1;
  logic busy0, done0, ovf0, busy1, done1, ovf1;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, busy_cnt, probe_v;

  always #5 clk = ~clk;

  regfile_engine u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra(ra), .rb(rb), .w(w), .wd(wd),
    .rda(rda0), .rdb(rdb0), .busy(busy0), .done(done0), .ovf(ovf0)
  );

  regfile_engine #(.NREGS(20), .SATURATE(1), .ZERO_R0(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra(ra), .rb(rb), .w(w), .wd(wd),
    .rda(rda1), .rdb(rdb1), .busy(busy1), .done(done1), .ovf(ovf1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after accept, and wait (bounded) for done.
  // probe: cycle after T at which rda is sampled into probe_v.
  // poke:  cycle after T at which a WRITE w=4 wd=99 request is raised for one edge.
  task automatic run_op(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] wa, input logic signed [15:0] d,
                        input int probe, input int poke);
    @(negedge clk);
    start = 1'b1; op = o; ra = a; rb = b; w = wa; wd = d;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 31));
    rb = 5'($urandom_range(0, 31)); w = 5'($urandom_range(0, 31));
    wd = 16'($urandom_range(0, 65535));
    lat = 0; busy_cnt = 0; probe_v = 0;
    while (done0 !== 1'b1 && lat < 200) begin
      if (busy0) busy_cnt++;
      if (lat == probe) probe_v = rda0;
      if (lat == poke) begin
        start = 1'b1; op = 3'd0; w = 5'd4; wd = 16'sd99;
      end
      if (lat == poke + 1) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (lat >= 200) check("timeout_waiting_done", lat, -1);
    check("u1_done_with_u0", done1, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; w = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rda", rda0, 0);
    check("reset_rdb", rdb0, 0);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_ovf", ovf0, 0);
    check("reset_busy_u1", busy1, 0);
    @(negedge clk); rst = 1'b0;

    // WRITE then READ1
    run_op(3'd0, 5'd0, 5'd0, 5'd1, 16'sd17, -1, -1);
    check("write_lat", lat, 2);
    check("write_rda", rda0, 17);
    run_op(3'd1, 5'd1, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("read1_lat", lat, 2);
    check("read1_rda", rda0, 17);

    // READ1_WRITE: read shows at T+2, done at T+4
    run_op(3'd3, 5'd1, 5'd0, 5'd2, -16'sd9, 2, -1);
    check("r1w_lat", lat, 4);
    check("r1w_rda_at_t2", probe_v, 17);
    check("r1w_rda_done", rda0, 17);
    run_op(3'd1, 5'd2, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("r1w_r2", rda0, -9);

    // READ1_WRITE with ra==w returns the old value
    run_op(3'd3, 5'd2, 5'd0, 5'd2, 16'sd100, -1, -1);
    check("r1w_same_old", rda0, -9);
    run_op(3'd1, 5'd2, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("r1w_same_new", rda0, 100);
    run_op(3'd0, 5'd0, 5'd0, 5'd2, -16'sd9, -1, -1);

    // ADD with an ignored start at T+5
    run_op(3'd5, 5'd1, 5'd2, 5'd4, 16'sd0, -1, 4);
    check("add_lat", lat, 20);
    check("add_busy_cycles", busy_cnt, 20);
    check("add_rda", rda0, 8);
    check("add_rdb", rdb0, -9);
    check("add_ovf", ovf0, 0);
    @(posedge clk); #1;
    check("add_done_one_cycle", done0, 0);
    check("add_no_queued_op", busy0, 0);
    run_op(3'd1, 5'd4, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("add_r4", rda0, 8);

    // SHIFT left and arithmetic right; rdb holds
    run_op(3'd0, 5'd0, 5'd0, 5'd3, 16'sd65, -1, -1);
    run_op(3'd7, 5'd3, 5'd0, 5'd5, 16'sd3, -1, -1);
    check("shl_lat", lat, 20);
    check("shl_rda", rda0, 520);
    check("shl_rdb_hold", rdb0, -9);
    run_op(3'd1, 5'd5, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("shl_r5", rda0, 520);
    run_op(3'd7, 5'd2, 5'd0, 5'd6, 16'sh8001, -1, -1);
    check("sar_rda", rda0, -5);

    // Overflow: wrap on u0, clamp on u1
    run_op(3'd0, 5'd0, 5'd0, 5'd1, 16'sd32767, -1, -1);
    run_op(3'd0, 5'd0, 5'd0, 5'd2, 16'sd1, -1, -1);
    run_op(3'd5, 5'd1, 5'd2, 5'd7, 16'sd0, -1, -1);
    check("addovf_wrap_rda", rda0, -32768);
    check("addovf_wrap_ovf", ovf0, 1);
    check("addovf_sat_rda", rda1, 32767);
    check("addovf_sat_ovf", ovf1, 1);
    run_op(3'd0, 5'd0, 5'd0, 5'd1, -16'sd32768, -1, -1);
    check("ovf_cleared_by_write", ovf0, 0);
    run_op(3'd6, 5'd1, 5'd2, 5'd8, 16'sd0, -1, -1);
    check("subovf_sat_rda", rda1, -32768);
    check("subovf_sat_ovf", ovf1, 1);
    check("subovf_wrap_rda", rda0, 32767);
    check("subovf_wrap_ovf", ovf0, 1);
    run_op(3'd1, 5'd8, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("subovf_r8_u0", rda0, 32767);
    check("subovf_r8_u1", rda1, -32768);

    // READ2
    run_op(3'd2, 5'd1, 5'd2, 5'd0, 16'sd0, -1, -1);
    check("read2_lat", lat, 2);
    check("read2_rda", rda0, -32768);
    check("read2_rdb", rdb0, 1);

    // Reset at T+10 of an ADD aborts it
    @(negedge clk);
    start = 1'b1; op = 3'd5; ra = 5'd1; rb = 5'd2; w = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    rst = 1'b0;
    lat = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done0) lat++;
    end
    check("abort_no_done_pulse", lat, 0);
    run_op(3'd1, 5'd4, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("abort_r4_not_written", rda0, 0);

    // Reset wins over start
    @(negedge clk); rst = 1'b1; start = 1'b1; op = 3'd0; w = 5'd3; wd = 16'sd7;
    @(posedge clk); #1;
    check("rst_over_start_busy", busy0, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // Hardwired-zero r0 on u1 only
    run_op(3'd0, 5'd0, 5'd0, 5'd0, 16'sd5, -1, -1);
    check("r0_write_rda_u1", rda1, 5);
    run_op(3'd1, 5'd0, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("r0_read_u1", rda1, 0);
    check("r0_read_u0", rda0, 5);

    // Out-of-range register on u1 (20 regs)
    run_op(3'd0, 5'd0, 5'd0, 5'd25, 16'sd33, -1, -1);
    run_op(3'd1, 5'd25, 5'd0, 5'd0, 16'sd0, -1, -1);
    check("oor_read_u0", rda0, 33);
    check("oor_read_u1", rda1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end
endmodule
